ticket_vend_ctrl: RTL and testbench

//  Top-level sequencer of the ticket vending machine. Accumulates coin credit.

---
 rtl/ticket_vend_ctrl_if.sv | 38 +++
 rtl/ticket_vend_ctrl.sv | 119 +++++++++++
 tb/tb_ticket_vend_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ticket_vend_ctrl_if.sv
// Signal bundle between the ticket vending controller and the coin acceptor / Ticketout side.
// Macro TICKET_VEND_CANCEL_EN adds the cancel request line.
interface ticket_vend_ctrl_if #(
    parameter int unsigned CREDIT_W = 5
) ();
    logic                coin_valid;
    logic [3:0]          coin_value;
    logic                state_cmp9;
`ifdef TICKET_VEND_CANCEL_EN
    logic                cancel;
`endif
    logic                out_RDY9;
    logic                coin_reject;
    logic                change_out;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
    logic                fault;

`ifdef TICKET_VEND_CANCEL_EN
    modport master (
        input  coin_valid, coin_value, state_cmp9, cancel,
        output out_RDY9, coin_reject, change_out, credit, busy, fault
    );
    modport slave (
        output coin_valid, coin_value, state_cmp9, cancel,
        input  out_RDY9, coin_reject, change_out, credit, busy, fault
    );
`else
    modport master (
        input  coin_valid, coin_value, state_cmp9,
        output out_RDY9, coin_reject, change_out, credit, busy, fault
    );
    modport slave (
        output coin_valid, coin_value, state_cmp9,
        input  out_RDY9, coin_reject, change_out, credit, busy, fault
    );
`endif
endinterface

// File: rtl/ticket_vend_ctrl.sv
// Ticket vending sequencer: collects coin credit, requests a ticket, pays back change.
// Macro TICKET_VEND_CANCEL_EN enables the cancel/refund request while collecting.
module ticket_vend_ctrl #(
    parameter int unsigned PRICE       = 9,
    parameter int unsigned CREDIT_W    = 5,
    parameter int unsigned MAX_CREDIT  = 20,
    parameter int unsigned REQ_CYC     = 2,
    parameter int unsigned TKT_TIMEOUT = 32
) (
    input logic                clk,
    input logic                rst,
    ticket_vend_ctrl_if.master bus
);
    localparam int unsigned TMR_MAX = (TKT_TIMEOUT > REQ_CYC) ? TKT_TIMEOUT : REQ_CYC;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned SUM_W   = CREDIT_W + 1;

    typedef enum logic [2:0] {StIdle, StCollect, StReq, StWaitTkt, StChange} state_e;

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                reject_q, reject_d;
    logic                fault_q, fault_d;
    logic                coin_legal, coin_ok, cancel_req;
    logic [SUM_W-1:0]    coin_sum;

`ifdef TICKET_VEND_CANCEL_EN
    assign cancel_req = bus.cancel;
`else
    assign cancel_req = 1'b0;
`endif

    // Extra sum bit keeps the ceiling check free of wrap-around.
    assign coin_sum   = {1'b0, credit_q} + SUM_W'(bus.coin_value);
    assign coin_legal = (bus.coin_value == 4'd1) || (bus.coin_value == 4'd2) ||
                        (bus.coin_value == 4'd5) || (bus.coin_value == 4'd10);
    assign coin_ok    = bus.coin_valid && coin_legal && !cancel_req &&
                        (coin_sum <= SUM_W'(MAX_CREDIT)) &&
                        ((state_q == StIdle) || (state_q == StCollect));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            credit_q <= '0;
            timer_q  <= '0;
            reject_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            timer_q  <= timer_d;
            reject_q <= reject_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        timer_d  = timer_q;
        reject_d = 1'b0;
        fault_d  = 1'b0;

        if (coin_ok) begin
            credit_d = coin_sum[CREDIT_W-1:0];
        end else if (bus.coin_valid) begin
            reject_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (coin_ok) state_d = StCollect;
            end
            StCollect: begin
                if (cancel_req && (credit_q != '0)) begin
                    state_d = StChange;
                end else if (credit_q >= CREDIT_W'(PRICE)) begin
                    state_d = StReq;
                    timer_d = '0;
                end
            end
            StReq: begin
                if (timer_q == TMR_W'(REQ_CYC - 1)) begin
                    state_d = StWaitTkt;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            StWaitTkt: begin
                // Completion wins over a same-cycle timeout.
                if (bus.state_cmp9) begin
                    credit_d = credit_q - CREDIT_W'(PRICE);
                    state_d  = (credit_q == CREDIT_W'(PRICE)) ? StIdle : StChange;
                end else if (timer_q == TMR_W'(TKT_TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    state_d = StChange;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            StChange: begin
                if (credit_q != '0) credit_d = credit_q - CREDIT_W'(1);
                if (credit_q <= CREDIT_W'(1)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.out_RDY9    = (state_q == StReq);
        bus.change_out  = (state_q == StChange);
        bus.busy        = (state_q != StIdle) && (state_q != StCollect);
        bus.credit      = credit_q;
        bus.coin_reject = reject_q;
        bus.fault       = fault_q;
    end
endmodule

// File: tb/tb_ticket_vend_ctrl.sv
// Self-checking bench for ticket_vend_ctrl: cycle-level reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_ticket_vend_ctrl;
    localparam int PRICE       = 9;
    localparam int CREDIT_W    = 5;
    localparam int MAX_CREDIT  = 20;
    localparam int REQ_CYC     = 2;
    localparam int TKT_TIMEOUT = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ticket_vend_ctrl_if #(.CREDIT_W(CREDIT_W)) bus ();

    ticket_vend_ctrl #(
        .PRICE      (PRICE),
        .CREDIT_W   (CREDIT_W),
        .MAX_CREDIT (MAX_CREDIT),
        .REQ_CYC    (REQ_CYC),
        .TKT_TIMEOUT(TKT_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

`ifdef TICKET_VEND_CANCEL_EN
    wire cn_now = bus.cancel;
`else
    wire cn_now = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding request cycles, elapsed wait cycles (-1 = not waiting)
    // and change units still owed.
    typedef struct {
        int credit;
        int req;
        int wt;
        int chg;
        bit rej;
        bit flt;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t step(input mstate_t s, input bit cv, input int val,
                                     input bit cmp, input bit cn);
        mstate_t n = s;
        bit open_for_coins;
        bit legal;
        n.rej = 1'b0;
        n.flt = 1'b0;
        open_for_coins = (s.req == 0) && (s.wt < 0) && (s.chg == 0);
        legal = (val == 1) || (val == 2) || (val == 5) || (val == 10);
        if (cv) begin
            if (legal && open_for_coins && !cn && (s.credit + val <= MAX_CREDIT))
                n.credit = s.credit + val;
            else
                n.rej = 1'b1;
        end
        if (s.chg > 0) begin
            n.chg    = s.chg - 1;
            n.credit = s.credit - 1;
        end else if (s.req > 0) begin
            n.req = s.req - 1;
            if (n.req == 0) n.wt = 0;
        end else if (s.wt >= 0) begin
            if (cmp) begin
                n.credit = s.credit - PRICE;
                n.chg    = n.credit;
                n.wt     = -1;
            end else if (s.wt == TKT_TIMEOUT - 1) begin
                n.flt = 1'b1;
                n.chg = s.credit;
                n.wt  = -1;
            end else begin
                n.wt = s.wt + 1;
            end
        end else if (cn && s.credit > 0) begin
            n.chg = s.credit;
        end else if (s.credit >= PRICE) begin
            n.req = REQ_CYC;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '{credit: 0, req: 0, wt: -1, chg: 0, rej: 1'b0, flt: 1'b0};
        else     m <= step(m, bus.coin_valid, int'(bus.coin_value), bus.state_cmp9, cn_now);
    end

    initial begin
        forever begin
            @(negedge clk);
            check("credit",      int'(bus.credit),      m.credit);
            check("out_RDY9",    int'(bus.out_RDY9),    int'(m.req > 0));
            check("change_out",  int'(bus.change_out),  int'(m.chg > 0));
            check("busy",        int'(bus.busy),        int'(m.req > 0 || m.wt >= 0 || m.chg > 0));
            check("coin_reject", int'(bus.coin_reject), int'(m.rej));
            check("fault",       int'(bus.fault),       int'(m.flt));
        end
    end

    int n_rdy = 0, n_chg = 0, n_flt = 0, n_rej = 0;
    always @(negedge clk) begin
        n_rdy <= n_rdy + int'(bus.out_RDY9);
        n_chg <= n_chg + int'(bus.change_out);
        n_flt <= n_flt + int'(bus.fault);
        n_rej <= n_rej + int'(bus.coin_reject);
    end

    int r0, c0, f0, j0;
    task automatic snap();
        r0 = n_rdy; c0 = n_chg; f0 = n_flt; j0 = n_rej;
    endtask

    task automatic deltas(input string tag, input int rdy, input int chg, input int flt,
                          input int rej);
        check({tag, " rdy cycles"},    n_rdy - r0, rdy);
        check({tag, " change cycles"}, n_chg - c0, chg);
        check({tag, " fault pulses"},  n_flt - f0, flt);
        check({tag, " reject pulses"}, n_rej - j0, rej);
    endtask

    function automatic bit cond(input int what);
        case (what)
            0:       return !bus.busy;
            1:       return bus.busy && !bus.out_RDY9 && !bus.change_out;
            default: return bus.change_out;
        endcase
    endfunction

    task automatic wait_for(input int what, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (cond(what)) return;
            @(negedge clk);
        end
        check(name, int'(cond(what)), 1);
    endtask

    task automatic drive_coin(input int v);
        @(negedge clk);
        bus.coin_valid = 1'b1;
        bus.coin_value = 4'(v);
    endtask

    task automatic release_coin();
        @(negedge clk);
        bus.coin_valid = 1'b0;
        bus.coin_value = 4'd0;
    endtask

    task automatic ticket();
        @(negedge clk);
        bus.state_cmp9 = 1'b1;
        @(negedge clk);
        bus.state_cmp9 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.coin_valid = 1'b0;
        bus.coin_value = 4'd0;
        bus.state_cmp9 = 1'b0;
`ifdef TICKET_VEND_CANCEL_EN
        bus.cancel = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset credit", int'(bus.credit), 0);
        check("reset busy",   int'(bus.busy), 0);
        check("reset rdy",    int'(bus.out_RDY9), 0);
        rst = 1'b0;

        // Exact fare
        snap();
        drive_coin(5); drive_coin(2); drive_coin(2); release_coin();
        check("exact credit", int'(bus.credit), 9);
        check("exact model credit", m.credit, 9);
        wait_for(1, 20, "exact reach wait");
        ticket();
        wait_for(0, 20, "exact idle");
        check("exact final credit", int'(bus.credit), 0);
        deltas("exact", 2, 0, 0, 0);

        // Overpay; the 2 lands in the same cycle credit first reaches the price
        snap();
        drive_coin(10); drive_coin(2); release_coin();
        check("overpay credit", int'(bus.credit), 12);
        wait_for(1, 20, "overpay reach wait");
        ticket();
        wait_for(0, 20, "overpay idle");
        check("overpay final credit", int'(bus.credit), 0);
        deltas("overpay", 2, 3, 0, 0);

        // Exactly at the ceiling
        snap();
        drive_coin(10); drive_coin(10); release_coin();
        check("ceiling credit", int'(bus.credit), 20);
        wait_for(1, 20, "ceiling reach wait");
        ticket();
        wait_for(0, 30, "ceiling idle");
        deltas("ceiling", 2, 11, 0, 0);

        // Rejections: stray completion, illegal coin, over ceiling, coin while waiting
        snap();
        ticket();
        check("stray cmp credit", int'(bus.credit), 0);
        drive_coin(3); release_coin();
        check("illegal credit", int'(bus.credit), 0);
        drive_coin(1); drive_coin(10); drive_coin(10); release_coin();
        check("over ceiling credit", int'(bus.credit), 11);
        wait_for(1, 20, "reject reach wait");
        drive_coin(2); release_coin();
        ticket();
        wait_for(0, 20, "reject idle");
        deltas("reject", 2, 2, 0, 3);

        // Ticketout timeout: full refund
        snap();
        drive_coin(10); release_coin();
        wait_for(1, 20, "timeout reach wait");
        wait_for(0, 100, "timeout idle");
        check("timeout final credit", int'(bus.credit), 0);
        deltas("timeout", 2, 10, 1, 0);

        // Async reset mid-change
        drive_coin(10); drive_coin(1); release_coin();
        wait_for(1, 20, "reset reach wait");
        ticket();
        wait_for(2, 20, "reset reach change");
        check("pre-reset credit", int'(bus.credit), 2);
        #1 rst = 1'b1;
        #1;
        check("async change_out", int'(bus.change_out), 0);
        check("async credit",     int'(bus.credit), 0);
        check("async busy",       int'(bus.busy), 0);
        check("async model credit", m.credit, 0);
        snap();
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        deltas("post-reset", 0, 0, 0, 0);

`ifdef TICKET_VEND_CANCEL_EN
        // Cancel refunds everything; a coin beside it is returned
        snap();
        drive_coin(5); drive_coin(2); release_coin();
        check("cancel credit", int'(bus.credit), 7);
        @(negedge clk);
        bus.cancel = 1'b1; bus.coin_valid = 1'b1; bus.coin_value = 4'd1;
        @(negedge clk);
        bus.cancel = 1'b0; bus.coin_valid = 1'b0; bus.coin_value = 4'd0;
        wait_for(0, 20, "cancel idle");
        check("cancel final credit", int'(bus.credit), 0);
        deltas("cancel", 0, 7, 0, 1);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
